// File: rtl/i2c_tx_fifo_sequencer.sv
// TX sequencer: START, then pop xfer_len bytes from the sync FIFO into the I2C byte engine, then STOP.
// Optional FIFO-starvation abort is compiled in with `define I2C_TX_STARVE_TIMEOUT_EN.
module i2c_tx_fifo_sequencer #(
   parameter int data_width   = 8,
   parameter int len_width    = 8,
   parameter int starve_limit = 255
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start_req,
   input  logic [len_width-1:0]  xfer_len,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [len_width-1:0]  bytes_sent,
   output logic                  fifo_rd_req,
   input  logic [data_width-1:0] fifo_rd_data,
   input  logic                  fifo_empty,
   output logic                  eng_start,
   output logic                  eng_stop,
   output logic [data_width-1:0] eng_byte,
   output logic                  eng_byte_valid,
   input  logic                  eng_byte_ready,
   input  logic                  eng_nack,
   input  logic                  eng_cmd_done
);

   typedef enum logic [2:0] {
      s_idle,
      s_start,
      s_fetch,
      s_wait_data,
      s_send,
      s_stop
   } state_t;

   state_t                state_q, state_d;
   logic [len_width-1:0]  remaining_q, remaining_d;
   logic [len_width-1:0]  bytes_sent_q, bytes_sent_d;
   logic                  error_q, error_d;
   logic                  done_q, done_d;
   logic [data_width-1:0] eng_byte_q, eng_byte_d;

`ifdef I2C_TX_STARVE_TIMEOUT_EN
   localparam int starve_w = (starve_limit > 1) ? $clog2(starve_limit + 1) : 1;
   logic [starve_w-1:0] starve_q, starve_d;
`endif

   // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
   always_comb begin
      state_d        = state_q;
      remaining_d    = remaining_q;
      bytes_sent_d   = bytes_sent_q;
      error_d        = error_q;
      done_d         = 1'b0;
      eng_byte_d     = eng_byte_q;
      busy           = (state_q != s_idle);
      fifo_rd_req    = 1'b0;
      eng_start      = 1'b0;
      eng_stop       = 1'b0;
      eng_byte_valid = 1'b0;
`ifdef I2C_TX_STARVE_TIMEOUT_EN
      starve_d       = starve_q;
`endif

      case (state_q)
         s_idle: begin
            if (start_req) begin
               error_d      = 1'b0;
               bytes_sent_d = '0;
               if (xfer_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  remaining_d = xfer_len;
                  state_d     = s_start;
               end
            end
         end

         s_start: begin
            eng_start = 1'b1;
            if (eng_cmd_done) begin
               state_d = s_fetch;
`ifdef I2C_TX_STARVE_TIMEOUT_EN
               starve_d = '0;
`endif
            end
         end

         s_fetch: begin
            if (!fifo_empty) begin
               fifo_rd_req = 1'b1;
               state_d     = s_wait_data;
`ifdef I2C_TX_STARVE_TIMEOUT_EN
               starve_d    = '0;
            end else if (starve_q == starve_w'(starve_limit - 1)) begin
               // This empty cycle is the starve_limit-th one in a row.
               error_d = 1'b1;
               state_d = s_stop;
            end else begin
               starve_d = starve_q + starve_w'(1);
`endif
            end
         end

         s_wait_data: begin
            // FIFO read data is registered, so it is valid only now.
            eng_byte_d = fifo_rd_data;
            state_d    = s_send;
         end

         s_send: begin
            eng_byte_valid = 1'b1;
            if (eng_byte_ready) begin
               if (eng_nack) begin
                  error_d = 1'b1;
                  state_d = s_stop;
               end else begin
                  bytes_sent_d = bytes_sent_q + len_width'(1);
                  remaining_d  = remaining_q - len_width'(1);
                  if (remaining_q == len_width'(1)) begin
                     state_d = s_stop;
                  end else begin
                     state_d = s_fetch;
`ifdef I2C_TX_STARVE_TIMEOUT_EN
                     starve_d = '0;
`endif
                  end
               end
            end
         end

         s_stop: begin
            eng_stop = 1'b1;
            if (eng_cmd_done) begin
               done_d  = 1'b1;
               state_d = s_idle;
            end
         end

         default: state_d = s_idle;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= s_idle;
         remaining_q  <= '0;
         bytes_sent_q <= '0;
         error_q      <= 1'b0;
         done_q       <= 1'b0;
         eng_byte_q   <= '0;
`ifdef I2C_TX_STARVE_TIMEOUT_EN
         starve_q     <= '0;
`endif
      end else begin
         state_q      <= state_d;
         remaining_q  <= remaining_d;
         bytes_sent_q <= bytes_sent_d;
         error_q      <= error_d;
         done_q       <= done_d;
         eng_byte_q   <= eng_byte_d;
`ifdef I2C_TX_STARVE_TIMEOUT_EN
         starve_q     <= starve_d;
`endif
      end
   end

   assign done       = done_q;
   assign error      = error_q;
   assign bytes_sent = bytes_sent_q;
   assign eng_byte   = eng_byte_q;

endmodule

// File: tb/tb_i2c_tx_fifo_sequencer.sv
// Self-checking bench for i2c_tx_fifo_sequencer: queue-based FIFO and engine models plus a transfer-level reference model.
module tb_i2c_tx_fifo_sequencer;

   localparam int DW     = 8;
   localparam int LW     = 8;
   localparam int STARVE = 8;

   logic          clock = 1'b0;
   logic          reset;
   logic          start_req;
   logic [LW-1:0] xfer_len;
   logic          busy, done, error;
   logic [LW-1:0] bytes_sent;
   logic          fifo_rd_req;
   logic [DW-1:0] fifo_rd_data;
   logic          fifo_empty;
   logic          eng_start, eng_stop;
   logic [DW-1:0] eng_byte;
   logic          eng_byte_valid;
   logic          eng_byte_ready;
   logic          eng_nack;
   logic          eng_cmd_done;

   always #5 clock = ~clock;

   i2c_tx_fifo_sequencer #(
      .data_width  (DW),
      .len_width   (LW),
      .starve_limit(STARVE)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .start_req     (start_req),
      .xfer_len      (xfer_len),
      .busy          (busy),
      .done          (done),
      .error         (error),
      .bytes_sent    (bytes_sent),
      .fifo_rd_req   (fifo_rd_req),
      .fifo_rd_data  (fifo_rd_data),
      .fifo_empty    (fifo_empty),
      .eng_start     (eng_start),
      .eng_stop      (eng_stop),
      .eng_byte      (eng_byte),
      .eng_byte_valid(eng_byte_valid),
      .eng_byte_ready(eng_byte_ready),
      .eng_nack      (eng_nack),
      .eng_cmd_done  (eng_cmd_done)
   );

   // Transfer-level reference: which bus phase we are in and what the host-visible status must be.
   typedef enum logic [1:0] {P_IDLE, P_OPEN, P_DATA, P_CLOSE} phase_t;

   int            checks   = 0;
   int            failures = 0;
   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] log_q[$];
   phase_t        phase    = P_IDLE;
   int            remaining, pops_xfer, hs_xfer, age, starve;
   logic [DW-1:0] exp_byte = '0;
   logic          exp_done = 1'b0;
   logic          exp_err  = 1'b0;
   int            exp_bs   = 0;
   int            ready_pct = 100;
   int            nack_pct  = 0;
   int            nack_at   = 0;
   int            cmd_wait  = 0;
   bit            saw_done;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: compare at negedge, advance the model across the coming edge, drive inputs 1ns after it.
   task automatic tick();
      logic          exp_rd, exp_valid, popped;
      logic          nxt_cmd, nxt_rdy, nxt_nack;
      logic [DW-1:0] nb;
      @(negedge clock);
      exp_rd    = (phase == P_DATA) && (pops_xfer == hs_xfer) && !fifo_empty;
      exp_valid = (phase == P_DATA) && (pops_xfer == hs_xfer + 1) && (age >= 1);
      check("busy", busy, phase != P_IDLE);
      check("done", done, exp_done);
      check("error", error, exp_err);
      check("bytes_sent", bytes_sent, exp_bs);
      check("eng_start", eng_start, phase == P_OPEN);
      check("eng_stop", eng_stop, phase == P_CLOSE);
      check("fifo_rd_req", fifo_rd_req, exp_rd);
      check("eng_byte_valid", eng_byte_valid, exp_valid);
      if (exp_valid) check("eng_byte", eng_byte, exp_byte);
      if (done) saw_done = 1'b1;
      if (eng_byte_valid && eng_byte_ready && !eng_nack) log_q.push_back(eng_byte);

      popped = 1'b0;
      nb     = '0;
      if (fifo_rd_req && fifo_q.size() > 0) begin
         nb     = fifo_q.pop_front();
         popped = 1'b1;
      end

      exp_done = 1'b0;
      case (phase)
         P_IDLE: if (start_req) begin
            exp_err = 1'b0;
            exp_bs  = 0;
            if (xfer_len == '0) exp_done = 1'b1;
            else begin
               phase     = P_OPEN;
               remaining = int'(xfer_len);
               pops_xfer = 0;
               hs_xfer   = 0;
            end
         end
         P_OPEN: if (eng_cmd_done) begin
            phase  = P_DATA;
            starve = 0;
         end
         P_DATA: begin
            if (exp_rd) begin
               pops_xfer++;
               age      = 0;
               starve   = 0;
               exp_byte = nb;
            end else if (exp_valid) begin
               if (eng_byte_ready) begin
                  hs_xfer++;
                  starve = 0;
                  if (eng_nack) begin
                     exp_err = 1'b1;
                     phase   = P_CLOSE;
                  end else begin
                     exp_bs++;
                     remaining--;
                     if (remaining == 0) phase = P_CLOSE;
                  end
               end
            end else if (pops_xfer == hs_xfer + 1) begin
               age++;
`ifdef I2C_TX_STARVE_TIMEOUT_EN
            end else begin
               starve++;
               if (starve == STARVE) begin
                  exp_err = 1'b1;
                  phase   = P_CLOSE;
               end
`endif
            end
         end
         P_CLOSE: if (eng_cmd_done) begin
            phase    = P_IDLE;
            exp_done = 1'b1;
         end
         default: phase = P_IDLE;
      endcase

      nxt_cmd = 1'b0;
      if (!eng_cmd_done && (phase == P_OPEN || phase == P_CLOSE)) begin
         if (cmd_wait == 0) begin
            nxt_cmd  = 1'b1;
            cmd_wait = int'($urandom_range(3));
         end else cmd_wait--;
      end
      nxt_rdy  = int'($urandom_range(99)) < ready_pct;
      nxt_nack = (nack_at != 0 && hs_xfer + 1 == nack_at) || (int'($urandom_range(99)) < nack_pct);

      @(posedge clock);
      #1;
      if (popped) fifo_rd_data = nb;
      fifo_empty     = (fifo_q.size() == 0);
      eng_cmd_done   = nxt_cmd;
      eng_byte_ready = nxt_rdy;
      eng_nack       = nxt_nack;
      start_req      = 1'b0;
   endtask

   task automatic push(input logic [DW-1:0] b);
      fifo_q.push_back(b);
      fifo_empty = 1'b0;
   endtask

   task automatic flush_fifo();
      fifo_q.delete();
      fifo_empty = 1'b1;
   endtask

   task automatic start(input int len);
      start_req = 1'b1;
      xfer_len  = LW'(len);
      log_q.delete();
      saw_done  = 1'b0;
      tick();
   endtask

   task automatic run_until_done(input string name, input int max_cycles);
      for (int i = 0; i < max_cycles && !saw_done; i++) tick();
      check({name, "_done_seen"}, saw_done, 1'b1);
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_busy"}, busy, 1'b0);
      check({name, "_done"}, done, 1'b0);
      check({name, "_error"}, error, 1'b0);
      check({name, "_bytes_sent"}, bytes_sent, 0);
      check({name, "_rd_req"}, fifo_rd_req, 1'b0);
      check({name, "_eng_start"}, eng_start, 1'b0);
      check({name, "_eng_stop"}, eng_stop, 1'b0);
      check({name, "_eng_byte"}, eng_byte, 0);
      check({name, "_eng_valid"}, eng_byte_valid, 1'b0);
   endtask

   task automatic model_reset();
      phase        = P_IDLE;
      exp_done     = 1'b0;
      exp_err      = 1'b0;
      exp_bs       = 0;
      cmd_wait     = 0;
      eng_cmd_done = 1'b0;
      start_req    = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, failures so far %0d", failures);
      $fatal(1, "watchdog");
   end

   initial begin
      reset          = 1'b1;
      start_req      = 1'b0;
      xfer_len       = '0;
      fifo_rd_data   = '0;
      fifo_empty     = 1'b1;
      eng_byte_ready = 1'b0;
      eng_nack       = 1'b0;
      eng_cmd_done   = 1'b0;
      #2;
      check_all_zero("reset");
      tick();
      tick();
      reset = 1'b0;
      tick();

      // Three bytes, engine always ready, no NACK.
      push(8'hA1); push(8'hB2); push(8'hC3);
      start(3);
      run_until_done("t1", 100);
      check("t1_log_size", log_q.size(), 3);
      if (log_q.size() == 3) begin
         check("t1_byte0", log_q[0], 8'hA1);
         check("t1_byte1", log_q[1], 8'hB2);
         check("t1_byte2", log_q[2], 8'hC3);
      end
      check("t1_bytes_sent", bytes_sent, 3);
      check("t1_error", error, 1'b0);
      check("t1_fifo_left", fifo_q.size(), 0);

      // Five bytes queued, only two requested.
      for (int i = 0; i < 5; i++) push(LW'(8'h10 + i));
      start(2);
      run_until_done("t2", 100);
      check("t2_fifo_left", fifo_q.size(), 3);
      check("t2_bytes_sent", bytes_sent, 2);
      check("t2_last_byte", log_q.size() == 2 ? log_q[1] : 8'h00, 8'h11);
      flush_fifo();

      // NACK on the second handshake.
      for (int i = 0; i < 4; i++) push(LW'(8'h20 + i));
      nack_at = 2;
      start(4);
      run_until_done("t3", 100);
      nack_at = 0;
      check("t3_error", error, 1'b1);
      check("t3_bytes_sent", bytes_sent, 1);
      check("t3_fifo_left", fifo_q.size(), 2);
      flush_fifo();

`ifdef I2C_TX_STARVE_TIMEOUT_EN
      // Empty FIFO with the starvation abort compiled in.
      start(1);
      run_until_done("starve", 100);
      check("starve_error", error, 1'b1);
      check("starve_bytes_sent", bytes_sent, 0);
      check("starve_log_size", log_q.size(), 0);
`else
      // Empty FIFO: stall in FETCH, then data arrives late.
      start(1);
      for (int i = 0; i < 20; i++) tick();
      check("t4_stall_busy", busy, 1'b1);
      check("t4_stall_rd_req", fifo_rd_req, 1'b0);
      push(8'h5A);
      run_until_done("t4", 100);
      check("t4_byte", log_q.size() == 1 ? log_q[0] : 8'h00, 8'h5A);
      check("t4_bytes_sent", bytes_sent, 1);
`endif

      // Zero-length request: done only, no bus activity.
      start(0);
      run_until_done("t5", 5);
      check("t5_bytes_sent", bytes_sent, 0);

      // Asynchronous reset while a byte is offered to a stalled engine.
      push(8'h33); push(8'h44);
      ready_pct = 0;
      start(2);
      for (int i = 0; i < 50 && !eng_byte_valid; i++) tick();
      check("t6_reached_send", eng_byte_valid, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      check_all_zero("t6_async");
      model_reset();
      tick();
      tick();
      reset     = 1'b0;
      ready_pct = 100;
      tick();
      start(1);
      run_until_done("t6_fresh", 100);
      check("t6_fresh_byte", log_q.size() == 1 ? log_q[0] : 8'h00, 8'h44);
      check("t6_fifo_left", fifo_q.size(), 0);

      // Random traffic: sporadic requests (some while busy), random data arrival, ready and NACK.
      ready_pct = 70;
      nack_pct  = 8;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(99) < 4) begin
            start_req = 1'b1;
            xfer_len  = LW'($urandom_range(6));
         end
         if (fifo_q.size() < 12 && $urandom_range(99) < 35) push(DW'($urandom));
         tick();
      end
      nack_pct  = 0;
      ready_pct = 100;
      if (phase != P_IDLE) begin
         for (int i = 0; i < 8; i++) push(DW'($urandom));
         saw_done = 1'b0;
         run_until_done("rand_drain", 200);
      end
      tick();
      check("rand_end_busy", busy, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/i2c_tx_fifo_sequencer.md
Name: i2c_tx_fifo_sequencer

Overview:
- Transmit-side controller between the TX Sync FIFO read port and the I2C master byte engine.
- On a host start request it sequences START, then pops xfer_len bytes from the FIFO one at a time and hands each to the byte engine over a valid/ready handshake, then issues STOP.
- Reports busy, a done pulse, a sticky error flag and a bytes-sent count.
- Aborts cleanly on NACK and, optionally, on FIFO starvation.

Parameters:
- data_width, 8, FIFO word and I2C byte width.
- len_width, 8, width of the transfer length and byte counters.
- starve_limit, 255, FETCH cycles allowed with FIFO empty before abort; used only with I2C_TX_STARVE_TIMEOUT_EN.

Ports:
- clock, input, 1, single system clock; all logic on posedge.
- reset, input, 1, asynchronous, active-high; clears all state.
- start_req, input, 1, single-cycle request to begin a transfer; sampled only in IDLE.
- xfer_len, input, len_width, number of bytes to send; latched with start_req.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle pulse when the sequencer returns to IDLE after a transfer.
- error, output, 1, sticky abort flag; cleared by the next accepted start_req.
- bytes_sent, output, len_width, bytes accepted by the engine in the current or last transfer.
- fifo_rd_req, output, 1, FIFO pop strobe.
- fifo_rd_data, input, data_width, FIFO read data; registered, so valid the cycle after fifo_rd_req.
- fifo_empty, input, 1, FIFO empty status.
- eng_start, output, 1, request a START condition; held until eng_cmd_done.
- eng_stop, output, 1, request a STOP condition; held until eng_cmd_done.
- eng_byte, output, data_width, byte to transmit.
- eng_byte_valid, output, 1, eng_byte is valid.
- eng_byte_ready, input, 1, engine accepts eng_byte this cycle.
- eng_nack, input, 1, slave NACKed the byte; sampled only in the cycle where eng_byte_valid and eng_byte_ready are both high.
- eng_cmd_done, input, 1, one-cycle pulse when the engine finishes a START or STOP.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal remaining counter 0. Reset is asynchronous and may occur in any state. The FIFO is not flushed.
- States: IDLE, START, FETCH, WAIT_DATA, SEND, STOP.
- IDLE:
  - start_req with xfer_len != 0: latch remaining = xfer_len; clear bytes_sent and error; go to START.
  - start_req with xfer_len == 0: done pulses the next cycle; no bus activity; error cleared.
  - start_req outside IDLE is ignored.
- START: eng_start=1. On eng_cmd_done, go to FETCH.
- FETCH:
  - If !fifo_empty: fifo_rd_req=1 for exactly one cycle; go to WAIT_DATA.
  - If fifo_empty: stay in FETCH; fifo_rd_req=0 (stall).
- WAIT_DATA: latch fifo_rd_data into the eng_byte register at the end of this cycle; go to SEND.
- SEND: eng_byte_valid=1 with eng_byte held stable until handshake (valid && ready).
  - Handshake with eng_nack=1: set error; byte not counted; go to STOP.
  - Handshake with eng_nack=0: bytes_sent+1, remaining-1. If remaining was 1, go to STOP; otherwise go to FETCH.
- STOP: eng_stop=1. On eng_cmd_done, go to IDLE and pulse done in the same transition cycle (done high for one cycle).
- fifo_rd_req is never asserted when fifo_empty=1. No more than xfer_len pops per transfer.
- On NACK abort, the remaining FIFO bytes are left in the FIFO for firmware to handle.
- Minimum per-byte overhead: FETCH + WAIT_DATA + SEND = 3 cycles plus engine ready latency.
- eng_start and eng_stop are mutually exclusive and never asserted together with eng_byte_valid.
- Counter arithmetic: unsigned len_width, no wrap possible (bounded by xfer_len).

Optional Feature:
I2C_TX_STARVE_TIMEOUT_EN
- Defined:
  - A starve counter increments each FETCH cycle with fifo_empty=1 and resets on any pop or on entry to FETCH.
  - When the counter reaches starve_limit: set error; go to STOP.
- Not defined: FETCH waits indefinitely for data; starve_limit is unused and no counter logic is present.

Test Plan:
- Preload FIFO with 0xA1,0xB2,0xC3; start_req with xfer_len=3; engine ready always, no NACK -> eng_start until cmd_done; bytes A1,B2,C3 in order; 3 pops; eng_stop; done pulse; bytes_sent=3; error=0.
- FIFO holds 5 bytes; xfer_len=2 -> exactly 2 pops; 3 bytes remain in FIFO; bytes_sent=2.
- xfer_len=4; engine asserts eng_nack on the 2nd handshake -> error=1; bytes_sent=1; STOP issued; done pulse; 2 bytes remain in FIFO.
- FIFO empty; xfer_len=1 -> sequencer stalls in FETCH with busy=1 and fifo_rd_req=0; write 0x5A after 20 cycles -> byte 0x5A sent, then done.
- With I2C_TX_STARVE_TIMEOUT_EN and starve_limit=8: FIFO empty after START -> error=1 after 8 FETCH cycles; STOP issued; done pulse; bytes_sent=0.
- Assert reset while in SEND -> all outputs 0 immediately (asynchronously); state IDLE; a following start_req starts a fresh transfer.
